umiram_nport: RTL

Parametrised multi-port successor to the single-port UMI RAM model used by the switchboard examples. It presents NPORTS independent UMI device port pairs (request in, response out) in front of one shared word-addressed memory of DEPTH words. A round-robin arbiter picks one request per cycle and returns responses with reads, writes, posted writes and out-of-range error replies. It sits between `umi_rx_sim`/`umi_tx_sim` queue pairs in a testbench, or behind a UMI crossbar in a larger simulation model.

---
 rtl/umiram_pkg.sv | 21 ++
 rtl/umi_rr_arbiter.sv | 42 ++++
 rtl/umiram_nport.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/umiram_pkg.sv
// Shared opcode encodings and address helpers for the multi-port UMI RAM.
package umiram_pkg;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_W   = 8;

  localparam logic [OPC_W-1:0] REQ_RD     = 8'h01;
  localparam logic [OPC_W-1:0] RESP_RD    = 8'h02;
  localparam logic [OPC_W-1:0] REQ_WR     = 8'h03;
  localparam logic [OPC_W-1:0] RESP_WR    = 8'h04;
  localparam logic [OPC_W-1:0] REQ_POSTED = 8'h05;
  localparam logic [OPC_W-1:0] RESP_ERR   = 8'h06;

  // Byte address to word index; the full upper address is kept so the
  // caller can range-check it instead of silently wrapping.
  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input int unsigned bshift);
    return addr >> bshift;
  endfunction

endpackage

// File: rtl/umi_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among N requesters, pointer moves to
// the port after the winner.
module umi_rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  mask;
  logic [N-1:0]  hi_req;
  logic [N-1:0]  pick;

  // Prefer requests at or above the pointer, else wrap to the lowest request.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (i >= 32'(ptr_q));
    end
    hi_req = req_i & mask;
    pick   = (|hi_req) ? hi_req : req_i;
    gnt_o  = pick & (~pick + N'(1));
    ptr_d  = ptr_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_o[i]) begin
        ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/umiram_nport.sv
// Multi-port UMI RAM: NPORTS request/response pairs sharing one memory,
// one request served per cycle, registered per-port response slots.
// AW is assumed <= 64; DEPTH >= 2.
module umiram_nport
  import umiram_pkg::*;
#(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DW     = 256,
  parameter int unsigned AW     = 64,
  parameter int unsigned CW     = 32
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [NPORTS-1:0]    udev_req_valid,
  output logic [NPORTS-1:0]    udev_req_ready,
  input  logic [NPORTS*CW-1:0] udev_req_cmd,
  input  logic [NPORTS*AW-1:0] udev_req_dstaddr,
  input  logic [NPORTS*AW-1:0] udev_req_srcaddr,
  input  logic [NPORTS*DW-1:0] udev_req_data,
  output logic [NPORTS-1:0]    udev_resp_valid,
  input  logic [NPORTS-1:0]    udev_resp_ready,
  output logic [NPORTS*CW-1:0] udev_resp_cmd,
  output logic [NPORTS*AW-1:0] udev_resp_dstaddr,
  output logic [NPORTS*AW-1:0] udev_resp_srcaddr,
  output logic [NPORTS*DW-1:0] udev_resp_data
);

  localparam int unsigned BSHIFT = $clog2(DW / 8);
  localparam int unsigned IW     = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];

  logic [NPORTS-1:0]    elig;
  logic [NPORTS-1:0]    gnt;
  logic [CW-1:0]        sel_cmd;
  logic [AW-1:0]        sel_dst;
  logic [AW-1:0]        sel_src;
  logic [DW-1:0]        sel_data;
  logic [OPC_W-1:0]     sel_op;
  logic [63:0]          sel_widx;
  logic [IW-1:0]        mem_addr;
  logic                 in_range;
  logic                 mem_we;
  logic [DW-1:0]        rd_data;
  logic [OPC_W-1:0]     slot_op;
  logic [DW-1:0]        slot_data;
  logic                 unused_cmd_hi;

  logic [NPORTS-1:0]    resp_valid_q, resp_valid_d;
  logic [NPORTS*CW-1:0] resp_cmd_q,   resp_cmd_d;
  logic [NPORTS*AW-1:0] resp_dst_q,   resp_dst_d;
  logic [NPORTS*AW-1:0] resp_src_q,   resp_src_d;
  logic [NPORTS*DW-1:0] resp_data_q,  resp_data_d;

  // A port may compete if posted, or its slot is free or freeing this cycle.
  always_comb begin
    logic [OPC_W-1:0] op_i;
    op_i = '0;
    elig = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      op_i    = udev_req_cmd[i*CW + OPC_LSB +: OPC_W];
      elig[i] = nreset && udev_req_valid[i] &&
                ((op_i == REQ_POSTED) || !resp_valid_q[i] || udev_resp_ready[i]);
    end
  end

  umi_rr_arbiter #(.N(NPORTS)) u_arb (
    .clk_i  (clk),
    .rst_ni (nreset),
    .req_i  (elig),
    .gnt_o  (gnt)
  );

  assign udev_req_ready = gnt;

  // Route the granted port's request fields.
  always_comb begin
    sel_cmd  = '0;
    sel_dst  = '0;
    sel_src  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (gnt[i]) begin
        sel_cmd  = udev_req_cmd[i*CW +: CW];
        sel_dst  = udev_req_dstaddr[i*AW +: AW];
        sel_src  = udev_req_srcaddr[i*AW +: AW];
        sel_data = udev_req_data[i*DW +: DW];
      end
    end
  end

  assign sel_op        = sel_cmd[OPC_LSB +: OPC_W];
  assign unused_cmd_hi = ^sel_cmd[CW-1:OPC_W];
  assign sel_widx      = word_index(64'(sel_dst), BSHIFT);
  assign in_range      = (sel_widx < 64'(DEPTH));
  assign mem_addr      = sel_widx[IW-1:0];
  assign rd_data       = mem_q[mem_addr];
  assign mem_we        = (|gnt) && in_range &&
                         ((sel_op == REQ_WR) || (sel_op == REQ_POSTED));

  // Response opcode/data for the granted request.
  always_comb begin
    slot_op   = RESP_ERR;
    slot_data = '0;
    if (in_range && (sel_op == REQ_RD)) begin
      slot_op   = RESP_RD;
      slot_data = rd_data;
    end else if (in_range && (sel_op == REQ_WR)) begin
      slot_op = RESP_WR;
    end
  end

  // Memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= sel_data;
  end

  // Slot next-state: drain on handshake, load on a non-posted grant.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_cmd_d   = resp_cmd_q;
    resp_dst_d   = resp_dst_q;
    resp_src_d   = resp_src_q;
    resp_data_d  = resp_data_q;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (resp_valid_q[i] && udev_resp_ready[i]) resp_valid_d[i] = 1'b0;
      if (gnt[i] && (sel_op != REQ_POSTED)) begin
        resp_valid_d[i]          = 1'b1;
        resp_cmd_d[i*CW +: CW]   = CW'(slot_op);
        resp_dst_d[i*AW +: AW]   = sel_src;
        resp_src_d[i*AW +: AW]   = sel_dst;
        resp_data_d[i*DW +: DW]  = slot_data;
      end
    end
  end

  // Response slot registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      resp_valid_q <= '0;
      resp_cmd_q   <= '0;
      resp_dst_q   <= '0;
      resp_src_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_cmd_q   <= resp_cmd_d;
      resp_dst_q   <= resp_dst_d;
      resp_src_q   <= resp_src_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign udev_resp_valid   = resp_valid_q;
  assign udev_resp_cmd     = resp_cmd_q;
  assign udev_resp_dstaddr = resp_dst_q;
  assign udev_resp_srcaddr = resp_src_q;
  assign udev_resp_data    = resp_data_q;

endmodule
